// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control with mult/div busy tracking.
// Optional HAZARD_PERF_EN adds a 32-bit stall-cycle counter output.
module hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [1:0]  tuse_rs,
  input  logic [1:0]  tuse_rt,
  input  logic [4:0]  a3_E,
  input  logic [1:0]  tnew_E,
  input  logic [4:0]  a3_M,
  input  logic [1:0]  tnew_M,
  input  logic        md_use_D,
  input  logic        md_start,
  input  logic        md_is_div,
  input  logic        intreq,
  output logic        stall,
  output logic        clr_E,
  output logic        flush,
`ifdef HAZARD_PERF_EN
  output logic        md_busy,
  output logic [31:0] stall_cnt
`else
  output logic        md_busy
`endif
);
  logic [3:0] md_cnt, md_cnt_nx;
  logic stall_rs, stall_rt, stall_md;
  always_comb begin
    stall_rs = (rs_D != 5'd0) && ((rs_D == a3_E && tnew_E > tuse_rs) || (rs_D == a3_M && tnew_M > tuse_rs));
    stall_rt = (rt_D != 5'd0) && ((rt_D == a3_E && tnew_E > tuse_rt) || (rt_D == a3_M && tnew_M > tuse_rt));
    stall_md = md_use_D && (md_busy || md_start);
    stall = (stall_rs || stall_rt || stall_md) && !intreq;
    clr_E = stall;
    flush = intreq;
    md_busy = md_cnt != 4'd0;
    // A flushed E-stage op must not start the unit; a started op runs to completion.
    md_cnt_nx = (md_start && !intreq) ? (md_is_div ? 4'(DIV_CYC) : 4'(MULT_CYC))
              : (md_busy ? md_cnt - 4'd1 : 4'd0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) md_cnt <= 4'd0;
    else md_cnt <= md_cnt_nx;
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt <= 32'd0;
    else if (stall) stall_cnt <= stall_cnt + 32'd1;
`endif
endmodule
